// File: rtl/mem_bist_master.sv
// Pattern write / read-back self-test master for the valid/ready memory.
// Writes an address or LFSR pattern over a window, reads it back and reports errors.
module mem_bist_master #(
    parameter int          WIDTH      = 16,
    parameter int          DEPTH      = 16,
    parameter int          ADDR_WIDTH = $clog2(DEPTH),
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter logic [15:0] POLY       = 16'hB400
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   count,
    input  logic                  pattern_sel,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  wr_rd,
    output logic [WIDTH-1:0]      w_data,
    output logic                  valid,
    input  logic                  ready,
    input  logic [WIDTH-1:0]      r_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);

    localparam logic [WIDTH-1:0]    L_SEED  = WIDTH'(SEED);
    localparam logic [WIDTH-1:0]    L_POLY  = WIDTH'(POLY);
    localparam logic [ADDR_WIDTH:0] L_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_TURN,
        S_READ,
        S_FIN
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_sel;
    logic [ADDR_WIDTH:0]   r_idx;
    logic [WIDTH-1:0]      r_lfsr;
    logic [ADDR_WIDTH:0]   r_err;
    logic [ADDR_WIDTH-1:0] r_first;
    logic                  r_pass;

    logic [ADDR_WIDTH:0]   w_sum;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [WIDTH-1:0]      w_addr_ext;
    logic [WIDTH-1:0]      w_exp;
    logic [WIDTH-1:0]      w_lfsr_nxt;
    logic                  w_xfer;
    logic                  w_last;
    logic                  w_mis;
    logic [ADDR_WIDTH:0]   w_err_nxt;

    // Window address, expected pattern word and error bookkeeping
    always_comb begin
        w_sum      = {1'b0, r_base} + r_idx;
        w_addr     = ADDR_WIDTH'((w_sum >= L_DEPTH) ? w_sum - L_DEPTH : w_sum);
        w_addr_ext = '0;
        w_addr_ext[ADDR_WIDTH-1:0] = w_addr;
        w_exp      = r_sel ? r_lfsr : w_addr_ext;
        w_lfsr_nxt = (r_lfsr >> 1) ^ (r_lfsr[0] ? L_POLY : '0);
        w_xfer     = valid && ready;
        w_last     = (r_idx == r_count - 1'b1);
        w_mis      = (r_state == S_READ) && w_xfer && (r_data != w_exp);
        w_err_nxt  = r_err;
        if (w_mis && (r_err != '1)) begin
            w_err_nxt = r_err + 1'b1;
        end
    end

    // State register; reset abandons any run and drops valid at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and request/status outputs
    always_comb begin
        w_next = r_state;
        valid  = 1'b0;
        wr_rd  = 1'b0;
        w_data = '0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (count == '0) ? S_FIN : S_WRITE;
                end
            end
            S_WRITE: begin
                valid  = 1'b1;
                wr_rd  = 1'b1;
                w_data = w_exp;
                busy   = 1'b1;
                if (w_xfer && w_last) begin
                    w_next = S_TURN;
                end
            end
            S_TURN: begin
                busy   = 1'b1;
                w_next = S_READ;
            end
            S_READ: begin
                valid = 1'b1;
                busy  = 1'b1;
                if (w_xfer && w_last) begin
                    w_next = S_FIN;
                end
            end
            S_FIN: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Run parameters, index/LFSR sequencing and result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base  <= '0;
            r_count <= '0;
            r_sel   <= 1'b0;
            r_idx   <= '0;
            r_lfsr  <= L_SEED;
            r_err   <= '0;
            r_first <= '0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base  <= base_addr;
                        r_count <= count;
                        r_sel   <= pattern_sel;
                        r_idx   <= '0;
                        r_lfsr  <= L_SEED;
                        r_err   <= '0;
                        r_first <= '0;
                        r_pass  <= (count == '0);
                    end
                end
                S_WRITE: begin
                    if (w_xfer) begin
                        r_idx  <= r_idx + 1'b1;
                        r_lfsr <= w_lfsr_nxt;
                    end
                end
                S_TURN: begin
                    r_idx  <= '0;
                    r_lfsr <= L_SEED;
                end
                S_READ: begin
                    if (w_xfer) begin
                        r_idx  <= r_idx + 1'b1;
                        r_lfsr <= w_lfsr_nxt;
                        r_err  <= w_err_nxt;
                        if (w_mis && (r_err == '0)) begin
                            r_first <= w_addr;
                        end
                        if (w_last) begin
                            r_pass <= (w_err_nxt == '0);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign addr           = w_addr;
    assign pass           = r_pass;
    assign err_count      = r_err;
    assign first_err_addr = r_first;

endmodule

// File: tb/tb_mem_bist_master.sv
// Directed bench for mem_bist_master with a behavioural valid/ready memory.
// Memory model optionally stalls ready and corrupts selected read words.
module tb_mem_bist_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  base_addr = '0;
    logic [4:0]  count = '0;
    logic        pattern_sel = 1'b0;
    logic [3:0]  addr;
    logic        wr_rd;
    logic [15:0] w_data;
    logic        valid;
    logic        ready = 1'b0;
    logic [15:0] r_data = '0;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err_count;
    logic [3:0]  first_err_addr;

    mem_bist_master dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .count(count), .pattern_sel(pattern_sel), .addr(addr),
        .wr_rd(wr_rd), .w_data(w_data), .valid(valid), .ready(ready),
        .r_data(r_data), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // memory model state and monitor counters
    logic [15:0] mem [16];
    bit          rnd_mode = 0;
    bit          fault = 0;
    int          m_wait = 0;
    int          xfers = 0;
    int          vcyc = 0;
    int          gap = 0;
    int          viol = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    bit          stall_prev = 0;
    logic [3:0]  s_addr;
    logic [15:0] s_wdata;
    logic        s_wr;
    int          log_a[$];
    int          log_d[$];
    int          log_w[$];

    // Memory responder and bus monitor, acting between rising edges
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'hFFFF;
        forever begin
            @(negedge clk);
            if (valid) begin
                vcyc++;
                if (stall_prev && (addr !== s_addr || w_data !== s_wdata ||
                                   wr_rd !== s_wr)) viol++;
                if (m_wait > 0) begin
                    ready = 1'b0;
                    m_wait--;
                end else begin
                    ready = 1'b1;
                    r_data = mem[addr];
                    if (fault && (addr == 4'd3 || addr == 4'd9))
                        r_data[0] = ~r_data[0];
                end
                if (ready) begin
                    log_a.push_back(int'(addr));
                    log_d.push_back(int'(w_data));
                    log_w.push_back(int'(wr_rd));
                    if (wr_rd) mem[addr] = w_data;
                    xfers++;
                    m_wait = rnd_mode ? int'($urandom_range(0, 3)) : 0;
                    stall_prev = 0;
                end else begin
                    stall_prev = 1;
                    s_addr = addr;
                    s_wdata = w_data;
                    s_wr = wr_rd;
                end
            end else begin
                ready = rnd_mode ? 1'b0 : 1'b1;
                stall_prev = 0;
                if (busy) gap++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    int start_cyc = 0;

    task automatic clear_stats(input bit rnd, input bit flt);
        log_a.delete();
        log_d.delete();
        log_w.delete();
        xfers = 0;
        vcyc = 0;
        gap = 0;
        viol = 0;
        done_cnt = 0;
        rnd_mode = rnd;
        fault = flt;
        m_wait = rnd ? int'($urandom_range(0, 3)) : 0;
    endtask

    task automatic run(input int b, input int c, input bit sel,
                       input bit rnd, input bit flt, input bit inj);
        bit injected;
        bit inj_on;
        injected = 0;
        inj_on = 0;
        clear_stats(rnd, flt);
        @(negedge clk);
        base_addr = 4'(b);
        count = 5'(c);
        pattern_sel = sel;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        base_addr = 4'(b + 7);
        count = 5'd1;
        pattern_sel = ~sel;
        for (int n = 0; n < 400 && done_cnt == 0; n++) begin
            @(negedge clk);
            if (inj_on) begin
                start = 1'b0;
                inj_on = 0;
            end
            if (inj && !injected && valid && !wr_rd) begin
                start = 1'b1;
                base_addr = 4'd9;
                count = 5'd3;
                injected = 1;
                inj_on = 1;
            end
        end
        start = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    int e;
    int lf;

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_first", first_err_addr, 0);
        check("rst_addr", addr, 0);
        check("rst_wdata", w_data, 0);
        check("rst_wrrd", wr_rd, 0);
        rst = 1'b1;

        // reset mid-WRITE after five transfers
        clear_stats(0, 0);
        @(negedge clk);
        base_addr = 4'd0;
        count = 5'd16;
        pattern_sel = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 50 && xfers < 5; n++) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_valid", valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_addr", addr, 0);
        check("midrst_wrrd", wr_rd, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_nodone", done_cnt, 0);
        run(0, 16, 0, 0, 0, 0);
        check("restart_pass", pass, 1);

        // full sweep, ideal memory
        run(0, 16, 0, 0, 0, 0);
        check("sweep_xfers", xfers, 32);
        e = 0;
        for (int i = 0; i < 32 && i < log_a.size(); i++) begin
            if (log_a[i] != (i % 16)) e++;
            if (log_w[i] != (i < 16 ? 1 : 0)) e++;
            if (i < 16 && log_d[i] != i) e++;
        end
        check("sweep_seq", e, 0);
        check("sweep_gap", gap, 1);
        check("sweep_lat", done_cyc - start_cyc, 34);
        check("sweep_done", done_cnt, 1);
        check("sweep_pass", pass, 1);
        check("sweep_err", err_count, 0);
        check("sweep_first", first_err_addr, 0);

        // LFSR pattern with address wrap
        run(14, 4, 1, 0, 0, 0);
        check("lfsr_xfers", xfers, 8);
        if (log_a.size() >= 8) begin
            check("lfsr_a0", log_a[0], 14);
            check("lfsr_a1", log_a[1], 15);
            check("lfsr_a2", log_a[2], 0);
            check("lfsr_a3", log_a[3], 1);
            check("lfsr_d0", log_d[0], 16'hACE1);
            check("lfsr_d1", log_d[1], 16'hE270);
            check("lfsr_d2", log_d[2], 16'h7138);
            check("lfsr_d3", log_d[3], 16'h389C);
            check("lfsr_rd_a2", log_a[6], 0);
        end
        check("lfsr_pass", pass, 1);
        check("lfsr_lat", done_cyc - start_cyc, 10);

        // random back-pressure
        run(5, 16, 1, 1, 0, 0);
        check("bp_stable", viol, 0);
        check("bp_xfers", xfers, 32);
        e = 0;
        lf = 16'hACE1;
        for (int i = 0; i < 16 && i < log_d.size(); i++) begin
            if (log_d[i] != lf) e++;
            if (log_a[i] != ((5 + i) % 16)) e++;
            lf = (lf >> 1) ^ ((lf & 1) != 0 ? 16'hB400 : 0);
        end
        check("bp_wdata", e, 0);
        check("bp_pass", pass, 1);
        check("bp_done", done_cnt, 1);

        // corrupted reads at addresses 3 and 9
        run(0, 16, 0, 0, 1, 0);
        check("flt_pass", pass, 0);
        check("flt_err", err_count, 2);
        check("flt_first", first_err_addr, 3);

        // zero-length run
        run(6, 0, 0, 0, 0, 0);
        check("zero_lat", done_cyc - start_cyc, 1);
        check("zero_pass", pass, 1);
        check("zero_valid", vcyc, 0);
        check("zero_done", done_cnt, 1);

        // start pulse during READ is ignored
        run(2, 8, 0, 0, 0, 1);
        check("inj_done", done_cnt, 1);
        check("inj_xfers", xfers, 16);
        e = 0;
        for (int i = 8; i < 16 && i < log_a.size(); i++) begin
            if (log_a[i] != (2 + i - 8)) e++;
            if (log_w[i] != 0) e++;
        end
        check("inj_reads", e, 0);
        check("inj_pass", pass, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
